sha256_stream_loader: RTL
=========================

SHA256_STREAM_LOADER -- requirements
Module: sha256_stream_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, as listed below.
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous reset, active low
REQ-002 The block SHALL have these message stream input ports.
- s_valid  in  1  word valid
- s_ready  out  1  word accepted when s_valid and s_ready are both high
- s_data  in  32  big-endian: first byte in [31:24]
- s_bytes  in  3  valid bytes in the word, 1..4; 0 is legal only with s_last (message ends on the previous word)
- s_last  in  1  final word of the message
REQ-003 The block SHALL have these ports toward the sha256 register block.
- cs  out  1  chip select
- we  out  1  write enable
- address  out  8  register address
- write_data  out  32  write data
- read_data  in  32  combinational read data, valid in the same cycle as cs with we low
REQ-004 The block SHALL have these result ports.
- digest  out  256  word 0 in [255:224]
- digest_valid  out  1  one-cycle pulse
- busy  out  1  high from the first accepted word until digest_valid

Function
REQ-005 The FSM SHALL use the states IDLE, FILL, PAD, CTRL, WAIT, POLL, READ and DONE.
REQ-006 IDLE/FILL: s_ready SHALL be high. Each accepted word SHALL be written the same cycle (cs=1, we=1, address=0x10+widx, write_data = s_data with invalid bytes zeroed). widx SHALL be incremented, and the 32-bit byte counter SHALL be incremented by s_bytes.
REQ-007 When widx wraps 15->0 without s_last, the FSM SHALL go to CTRL. When s_last is accepted, it SHALL go to PAD. s_ready SHALL be low in every other state.
REQ-008 PAD SHALL write one word per cycle, as follows:
- The 0x80 marker goes in the byte directly after the last message byte; it is merged into the last word if s_bytes<4, otherwise it is written as 0x80000000 at the next widx.
- Words up to address 0x1D are zero.
- 0x1E = {29'b0, cnt[31:29]}.
- 0x1F = {cnt[28:0], 3'b0}.
REQ-009 If the marker lands at widx 14 or 15, the current block SHALL be zero-filled and processed via CTRL/WAIT/POLL. The FSM SHALL then return to PAD for a second block containing only zeros and the length.
REQ-010 CTRL SHALL write address 0x08 for one cycle with write_data 0x00000005 (init, SHA-256 mode) for the first block of a message, and 0x00000006 (next) otherwise.
REQ-011 WAIT SHALL idle with cs=0 for exactly 4 cycles after the CTRL write, to cover status register lag.
REQ-012 POLL SHALL read address 0x09 every cycle and leave POLL when read_data[0]=1 (ready):
- to FILL if the message is not finished;
- to PAD for the second padding block;
- to READ otherwise.
REQ-013 READ SHALL read addresses 0x20..0x27 on 8 consecutive cycles and capture each read_data into digest word 0..7.
REQ-014 DONE SHALL pulse digest_valid for 1 cycle, clear busy, widx, the byte counter and the first-block flag, then go to IDLE.
REQ-015 digest SHALL hold its value until the next DONE.
REQ-016 cs SHALL be 0 in any cycle with no access, and we SHALL be 0 whenever cs is 0.
REQ-017 Byte counter overflow beyond 2^32-1 bytes is unsupported, and the counter SHALL wrap silently.

Reset
REQ-018 While reset_n is low, the block SHALL hold the following values:
- state IDLE;
- s_ready, cs, we, digest_valid and busy 0;
- address and write_data 0;
- digest, counters and flags 0.
REQ-019 Reset mid-message SHALL abandon the message. The first word accepted after release SHALL start a new message with CTRL init.

Structure
REQ-020 Register addresses (0x08, 0x09, 0x10, 0x1F, 0x20), CTRL values 0x5/0x6, the WAIT length 4 and the state encoding SHALL live in the shared package sha256_pkg.
REQ-021 One sub-module, sha256_pad_word, SHALL be provided. It is combinational and maps (last data, s_bytes) to the masked word with marker merged.

Verification
REQ-022 Stimulus "abc" as one word 0x61626300 with s_bytes=3 and s_last SHALL produce digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad in one block, with 0x1F = 0x00000018.
REQ-023 An empty message (s_bytes=0, s_last) SHALL produce e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, with 0x10 = 0x80000000.
REQ-024 A 56-byte message SHALL take two blocks, with the second block all zero except 0x1F = 0x000001C0, and CTRL writes 0x5 then 0x6.
REQ-025 A 64-byte message SHALL produce a full first block and a second block starting 0x80000000 with 0x1F = 0x00000200. s_ready SHALL be low from CTRL until POLL sees ready.
REQ-026 Back-to-back messages with s_valid held high SHALL produce a second digest equal to a standalone run.
REQ-027 Reset asserted in POLL SHALL drive all outputs to 0 immediately, and a following "abc" run SHALL produce the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 stream loader: register map of the
// SHA-256 core, control command values, status settle time, FSM state
// encoding and byte-mask helpers used when packing message words.
package sha256_pkg;

  // Register map of the SHA-256 core
  localparam logic [7:0] ADDR_CTRL       = 8'h08;
  localparam logic [7:0] ADDR_STATUS     = 8'h09;
  localparam logic [7:0] ADDR_BLOCK      = 8'h10;
  localparam logic [7:0] ADDR_BLOCK_LAST = 8'h1F;
  localparam logic [7:0] ADDR_DIGEST     = 8'h20;

  // Control commands (SHA-256 mode bit set)
  localparam logic [31:0] CTRL_INIT = 32'h0000_0005;
  localparam logic [31:0] CTRL_NEXT = 32'h0000_0006;

  // Cycles the status register needs before it reflects a new command
  localparam logic [2:0] WAIT_CYCLES = 3'd4;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_PAD  = 3'd2;
  localparam logic [2:0] ST_CTRL = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_POLL = 3'd5;
  localparam logic [2:0] ST_READ = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  // Keep the first 'bytes' bytes of a big-endian word, zero the rest.
  function automatic logic [31:0] mask_word(input logic [31:0] data,
                                            input logic [2:0]  bytes);
    logic [31:0] m;
    case (bytes)
      3'd0:    m = 32'h0000_0000;
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      3'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return data & m;
  endfunction

  // 0x80 marker placed in the byte right after the last valid byte;
  // a full word leaves no room, so the marker goes into the next word.
  function automatic logic [31:0] marker_word(input logic [2:0] bytes);
    logic [31:0] m;
    case (bytes)
      3'd0:    m = 32'h8000_0000;
      3'd1:    m = 32'h0080_0000;
      3'd2:    m = 32'h0000_8000;
      3'd3:    m = 32'h0000_0080;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational last-word formatter.
// Ports:
//   data  - last message word, big-endian
//   bytes - number of valid bytes in data (0..4)
//   word  - data with invalid bytes cleared and the 0x80 marker merged
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  output logic [31:0] word
);

  assign word = mask_word(data, bytes) | marker_word(bytes);

endmodule

// File: rtl/sha256_stream_loader.sv
// Feeds a byte-counted word stream into a register-mapped SHA-256 core:
// loads 16-word blocks, appends the standard padding and 64-bit length,
// kicks the core, polls for completion and reads back the digest.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/
//   s_bytes/s_last               - message word stream
//   cs/we/address/write_data/
//   read_data                    - register bus toward the SHA-256 core
//   digest/digest_valid/busy     - result and status
module sha256_stream_loader
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic [2:0]   s_bytes,
  input  logic         s_last,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  logic [2:0]  state;
  logic        run;          // low for the first cycle after reset so s_ready stays low in reset
  logic [3:0]  widx;         // block word index, reused as digest word index in READ
  logic [31:0] cnt;          // message length in bytes
  logic        started;      // an init command was already issued for this message
  logic        msg_done;     // s_last has been accepted
  logic        marker_done;  // 0x80 marker has been written
  logic        len_hi_done;  // upper length word written in the current block
  logic        len_done;     // lower length word written, final block is loaded
  logic [2:0]  wait_cnt;
  logic [31:0] last_word;
  logic [31:0] pad_fill;
  logic [7:0]  blk_addr;
  logic        accept;

  sha256_pad_word u_pad (
    .data  (s_data),
    .bytes (s_bytes),
    .word  (last_word)
  );

  assign blk_addr     = ADDR_BLOCK + {4'h0, widx};
  assign s_ready      = run && ((state == ST_IDLE) || (state == ST_FILL));
  assign accept       = s_ready && s_valid;
  assign digest_valid = (state == ST_DONE);

  // Padding word for the current slot. The length only fits in a block
  // whose marker was written before slot 14; otherwise slots 14/15 get
  // zeros and the length moves to a second block.
  always_comb begin
    pad_fill = 32'h0;
    if (!marker_done)
      pad_fill = 32'h8000_0000;
    else if (blk_addr == ADDR_BLOCK_LAST - 8'd1)
      pad_fill = {29'b0, cnt[31:29]};
    else if ((blk_addr == ADDR_BLOCK_LAST) && len_hi_done)
      pad_fill = {cnt[28:0], 3'b0};
  end

  // Bus drive: stream words are written in the same cycle they are accepted
  always_comb begin
    cs         = 1'b0;
    we         = 1'b0;
    address    = 8'h00;
    write_data = 32'h0;
    case (state)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          cs         = 1'b1;
          we         = 1'b1;
          address    = blk_addr;
          write_data = s_last ? last_word : mask_word(s_data, s_bytes);
        end
      end
      ST_PAD: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = blk_addr;
        write_data = pad_fill;
      end
      ST_CTRL: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CTRL;
        write_data = started ? CTRL_NEXT : CTRL_INIT;
      end
      ST_POLL: begin
        cs      = 1'b1;
        address = ADDR_STATUS;
      end
      ST_READ: begin
        cs      = 1'b1;
        address = ADDR_DIGEST + {5'h0, widx[2:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      run         <= 1'b0;
      widx        <= 4'h0;
      cnt         <= 32'h0;
      started     <= 1'b0;
      msg_done    <= 1'b0;
      marker_done <= 1'b0;
      len_hi_done <= 1'b0;
      len_done    <= 1'b0;
      wait_cnt    <= 3'h0;
      busy        <= 1'b0;
      digest      <= 256'h0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE, ST_FILL: begin
          if (accept) begin
            busy <= 1'b1;
            widx <= widx + 4'd1;
            cnt  <= cnt + {29'b0, s_bytes};
            if (s_last) begin
              msg_done    <= 1'b1;
              marker_done <= (s_bytes < 3'd4);
            end
            // A full block is sent off first even if it carries s_last
            if (widx == 4'd15)
              state <= ST_CTRL;
            else if (s_last)
              state <= ST_PAD;
            else
              state <= ST_FILL;
          end
        end
        ST_PAD: begin
          widx <= widx + 4'd1;
          if (!marker_done)
            marker_done <= 1'b1;
          else if (blk_addr == ADDR_BLOCK_LAST - 8'd1)
            len_hi_done <= 1'b1;
          else if ((blk_addr == ADDR_BLOCK_LAST) && len_hi_done)
            len_done <= 1'b1;
          if (blk_addr == ADDR_BLOCK_LAST)
            state <= ST_CTRL;
        end
        ST_CTRL: begin
          started  <= 1'b1;
          wait_cnt <= 3'h0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_CYCLES - 3'd1)
            state <= ST_POLL;
          else
            wait_cnt <= wait_cnt + 3'd1;
        end
        ST_POLL: begin
          if (read_data[0]) begin
            if (len_done)
              state <= ST_READ;
            else if (msg_done)
              state <= ST_PAD;
            else
              state <= ST_FILL;
          end
        end
        ST_READ: begin
          digest[{3'd7 - widx[2:0], 5'd0} +: 32] <= read_data;
          if (widx[2:0] == 3'd7) begin
            widx  <= 4'h0;
            state <= ST_DONE;
          end else begin
            widx <= widx + 4'd1;
          end
        end
        ST_DONE: begin
          busy        <= 1'b0;
          widx        <= 4'h0;
          cnt         <= 32'h0;
          started     <= 1'b0;
          msg_done    <= 1'b0;
          marker_done <= 1'b0;
          len_hi_done <= 1'b0;
          len_done    <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
